skeeball_game_sequencer: RTL and testbench
==========================================

Name: skeeball_game_sequencer

Overview:
- Synchronous game controller for the skeeball machine; sequences MENU -> PLAYING -> FINISH -> SCORE using the existing 2-bit state encoding, so its state output feeds skeeballStateDecode unchanged.
- Arbitrates simultaneous hole-sensor hits, accumulates score and counts balls.
- Times the finish and score-display phases and latches the last game's score for display.

Parameters:
- NUM_BALLS, 9, balls per game (1..15).
- SCORE_W, 10, score/last_score width in bits.
- FINISH_CYCLES, 50000000, clk cycles spent in FINISH (>=1).
- SCORE_HOLD_CYCLES, 250000000, clk cycles in SCORE before auto-return to MENU (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start_btn  in  1  start button, level; rising edge detected internally
- hole_hit  in  6  hole sensors, level; bit i rising edge = ball in hole i; values 10,20,30,40,50,100 for i=0..5
- gutter_hit  in  1  ball-return sensor for a miss, level; rising edge detected
- state  out  2  00 MENU, 01 PLAYING, 10 FINISH, 11 SCORE
- score  out  SCORE_W  current game score
- balls_left  out  4  balls remaining
- last_score  out  SCORE_W  score of most recently completed game
- hit_pulse  out  1  one-cycle pulse when a hole hit is scored
- game_over  out  1  one-cycle pulse on the PLAYING->FINISH edge
- high_score  out  SCORE_W  see Optional Feature

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - state=00; score=0; balls_left=0; last_score=0; high_score=0; hit_pulse=0; game_over=0.
  - Phase counter cleared.
  - Edge-detect history registers set to 0, so an input held high through reset registers as a rise on the first cycle after reset.
- Edge detection:
  - rise = input & ~prev; prev registered every cycle.
  - Edge history updates in all states, including during reset release.
- MENU:
  - start rise -> PLAYING next cycle.
  - Same edge: score<=0, balls_left<=NUM_BALLS.
  - Hole and gutter edges ignored.
- PLAYING, per cycle:
  - Any hole rise: select highest set index among rising bits (fixed priority, highest value wins); score<=score+value; balls_left<=balls_left-1; hit_pulse=1.
  - Else gutter rise: balls_left<=balls_left-1; no score change.
  - Simultaneous multiple hole rises and/or gutter rise consume exactly one ball; the lower-priority hits are discarded.
  - Addition saturates at 2^SCORE_W-1.
  - If the decrement takes balls_left 1->0: same edge state<=FINISH, last_score<=final score (including this hit), game_over=1 for one cycle, phase counter cleared.
  - start rise ignored.
- FINISH:
  - Count FINISH_CYCLES cycles, then -> SCORE with counter cleared.
  - All inputs ignored.
- SCORE:
  - start rise -> PLAYING with score<=0, balls_left<=NUM_BALLS; new game, skipping MENU.
  - Else after SCORE_HOLD_CYCLES cycles -> MENU.
  - If start rises on the timeout cycle, start wins.
- score holds its value through FINISH, SCORE and MENU until the next game start.
- State 11 unreachable otherwise. There is no illegal encoding: all 4 states are used.
- Reset mid-game: immediate return to reset values; last_score is cleared.
- hit_pulse and game_over are registered outputs, asserted in the cycle after the causing edge.

Optional Feature:
- Macro SKEEBALL_HIGH_SCORE_EN.
- Defined: high_score register. On the PLAYING->FINISH edge, if the final score > high_score, then high_score<=final score. Ties do not update. Cleared only by reset.
- Undefined: high_score tied to 0 and no register is inferred. The port stays present.

Test Plan (NUM_BALLS=3, FINISH_CYCLES=4, SCORE_HOLD_CYCLES=6):
- Reset, start rise -> state 01 next cycle; balls_left=3; score=0.
- hole_hit bits 5,2 rise together -> score=100, balls_left=2, single hit_pulse. Then gutter rise -> balls_left=1, score=100.
- hole_hit[4] and gutter rise together -> score=150, balls_left=0, state 10, last_score=150, game_over one cycle.
- After FINISH: 4 cycles in 10 -> state 11; no start -> 6 cycles -> state 00; score still 150.
- In SCORE, start rise -> state 01, score=0, balls_left=3. Play 10,10,10 -> last_score=30. With SKEEBALL_HIGH_SCORE_EN, high_score stays 150; without it, high_score=0.
- Score saturation (SCORE_W=7): three hole-5 hits -> score=127. Reset asserted mid-PLAYING -> all outputs 0 and state 00 next cycle.

Source files
------------

// File: rtl/skeeball_game_sequencer.sv
// Skeeball game controller: MENU -> PLAYING -> FINISH -> SCORE, scoring and ball counting.
// Latency: outputs registered, one cycle after the sampled input edge; no backpressure (sensor inputs are edge-sampled every cycle).
// Optional high-score tracking enabled by defining SKEEBALL_HIGH_SCORE_EN.
module skeeball_game_sequencer #(
  parameter int NUM_BALLS         = 9,
  parameter int SCORE_W           = 10,
  parameter int FINISH_CYCLES     = 50000000,
  parameter int SCORE_HOLD_CYCLES = 250000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic [5:0]         hole_hit,
  input  logic               gutter_hit,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         balls_left,
  output logic [SCORE_W-1:0] last_score,
  output logic               hit_pulse,
  output logic               game_over,
  output logic [SCORE_W-1:0] high_score
);

  localparam int MAX_CYC = (FINISH_CYCLES > SCORE_HOLD_CYCLES) ? FINISH_CYCLES : SCORE_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    MENU    = 2'b00,
    PLAYING = 2'b01,
    FINISH  = 2'b10,
    SCORE   = 2'b11
  } state_t;

  state_t             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_d, last_d;
  logic [3:0]         balls_d;
  logic               hit_d, over_d;

  logic               start_prev, gutter_prev;
  logic [5:0]         hole_prev;
  logic               start_rise, gutter_rise;
  logic [5:0]         hole_rise;

  logic [SCORE_W:0]   hole_value, score_sum;
  logic [SCORE_W-1:0] score_sat;

  assign start_rise  = start_btn & ~start_prev;
  assign gutter_rise = gutter_hit & ~gutter_prev;
  assign hole_rise   = hole_hit & ~hole_prev;

  // Highest hole index wins when several balls register in the same cycle.
  always_comb begin
    hole_value = '0;
    if      (hole_rise[5]) hole_value = (SCORE_W+1)'(100);
    else if (hole_rise[4]) hole_value = (SCORE_W+1)'(50);
    else if (hole_rise[3]) hole_value = (SCORE_W+1)'(40);
    else if (hole_rise[2]) hole_value = (SCORE_W+1)'(30);
    else if (hole_rise[1]) hole_value = (SCORE_W+1)'(20);
    else if (hole_rise[0]) hole_value = (SCORE_W+1)'(10);
  end

  assign score_sum = {1'b0, score} + hole_value;
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    score_d = score;
    balls_d = balls_left;
    last_d  = last_score;
    hit_d   = 1'b0;
    over_d  = 1'b0;
    case (st_q)
      MENU: begin
        if (start_rise) begin
          st_d    = PLAYING;
          score_d = '0;
          balls_d = 4'(NUM_BALLS);
          cnt_d   = '0;
        end
      end
      PLAYING: begin
        // Any combination of simultaneous hits consumes exactly one ball.
        if ((|hole_rise) || gutter_rise) begin
          balls_d = balls_left - 4'd1;
          if (|hole_rise) begin
            score_d = score_sat;
            hit_d   = 1'b1;
          end
          if (balls_left == 4'd1) begin
            st_d   = FINISH;
            last_d = score_d;
            over_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      FINISH: begin
        if (cnt_q == CNT_W'(FINISH_CYCLES - 1)) begin
          st_d  = SCORE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCORE: begin
        // A start press on the timeout cycle takes precedence over returning to MENU.
        if (start_rise) begin
          st_d    = PLAYING;
          score_d = '0;
          balls_d = 4'(NUM_BALLS);
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SCORE_HOLD_CYCLES - 1)) begin
          st_d  = MENU;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= MENU;
      cnt_q       <= '0;
      score       <= '0;
      balls_left  <= '0;
      last_score  <= '0;
      hit_pulse   <= 1'b0;
      game_over   <= 1'b0;
      start_prev  <= 1'b0;
      gutter_prev <= 1'b0;
      hole_prev   <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      score       <= score_d;
      balls_left  <= balls_d;
      last_score  <= last_d;
      hit_pulse   <= hit_d;
      game_over   <= over_d;
      start_prev  <= start_btn;
      gutter_prev <= gutter_hit;
      hole_prev   <= hole_hit;
    end
  end

  assign state = st_q;

`ifdef SKEEBALL_HIGH_SCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      high_score <= '0;
    end else if (over_d && (last_d > high_score)) begin
      high_score <= last_d;
    end
  end
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_skeeball_game_sequencer.sv
// Bench for skeeball_game_sequencer: directed game walkthrough then random play on a 10-bit and a 7-bit score instance,
// both checked against a rule-level game model.
module tb_skeeball_game_sequencer;

  localparam int NB = 3;
  localparam int FC = 4;
  localparam int SH = 6;
`ifdef SKEEBALL_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       gutter_hit = 1'b0;
  logic [5:0] hole_hit = 6'b0;

  logic [1:0] state0, state1;
  logic [9:0] score0, last0, high0;
  logic [6:0] score1, last1, high1;
  logic [3:0] balls0, balls1;
  logic       hit0, hit1, go0, go1;

  int total = 0;
  int bad = 0;

  // Reference model: game phase, cycles spent in phase, balls, per-width scores.
  int mstate, mcnt, mballs, mhit, mgo;
  bit ps, pg;
  bit [5:0] ph;
  int msc[2], mlast[2], mhigh[2];
  int mx[2] = '{1023, 127};
  int hv[6] = '{10, 20, 30, 40, 50, 100};

  always #5 clk = ~clk;

  skeeball_game_sequencer #(.NUM_BALLS(NB), .SCORE_W(10), .FINISH_CYCLES(FC), .SCORE_HOLD_CYCLES(SH)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .hole_hit(hole_hit), .gutter_hit(gutter_hit),
    .state(state0), .score(score0), .balls_left(balls0), .last_score(last0),
    .hit_pulse(hit0), .game_over(go0), .high_score(high0));

  skeeball_game_sequencer #(.NUM_BALLS(NB), .SCORE_W(7), .FINISH_CYCLES(FC), .SCORE_HOLD_CYCLES(SH)) dut7 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .hole_hit(hole_hit), .gutter_hit(gutter_hit),
    .state(state1), .score(score1), .balls_left(balls1), .last_score(last1),
    .hit_pulse(hit1), .game_over(go1), .high_score(high1));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_game();
    mstate = 1;
    mballs = NB;
    mcnt   = 0;
    for (int k = 0; k < 2; k++) msc[k] = 0;
  endtask

  task automatic model_step();
    bit sr, gr;
    bit [5:0] hr;
    int v;
    mhit = 0;
    mgo  = 0;
    if (reset) begin
      mstate = 0; mcnt = 0; mballs = 0;
      ps = 0; pg = 0; ph = 0;
      for (int k = 0; k < 2; k++) begin msc[k] = 0; mlast[k] = 0; mhigh[k] = 0; end
      return;
    end
    sr = start_btn && !ps;
    gr = gutter_hit && !pg;
    hr = hole_hit & ~ph;
    ps = start_btn; pg = gutter_hit; ph = hole_hit;
    case (mstate)
      0: if (sr) new_game();
      1: if (hr != 0 || gr) begin
           v = 0;
           for (int i = 0; i < 6; i++) if (hr[i] && hv[i] > v) v = hv[i];
           if (v > 0) begin
             mhit = 1;
             for (int k = 0; k < 2; k++) msc[k] = (msc[k] + v > mx[k]) ? mx[k] : msc[k] + v;
           end
           mballs--;
           if (mballs == 0) begin
             mstate = 2; mcnt = 0; mgo = 1;
             for (int k = 0; k < 2; k++) begin
               mlast[k] = msc[k];
               if (msc[k] > mhigh[k]) mhigh[k] = msc[k];
             end
           end
         end
      2: begin
           mcnt++;
           if (mcnt == FC) begin mstate = 3; mcnt = 0; end
         end
      default: begin
           if (sr) new_game();
           else begin
             mcnt++;
             if (mcnt == SH) begin mstate = 0; mcnt = 0; end
           end
         end
    endcase
  endtask

  task automatic check_all();
    chk("state",      state0, mstate);
    chk("score",      score0, msc[0]);
    chk("balls",      balls0, mballs);
    chk("last_score", last0,  mlast[0]);
    chk("hit_pulse",  hit0,   mhit);
    chk("game_over",  go0,    mgo);
    chk("high_score", high0,  HS_EN ? mhigh[0] : 0);
    chk("state7",      state1, mstate);
    chk("score7",      score1, msc[1]);
    chk("balls7",      balls1, mballs);
    chk("last_score7", last1,  mlast[1]);
    chk("hit_pulse7",  hit1,   mhit);
    chk("game_over7",  go1,    mgo);
    chk("high_score7", high1,  HS_EN ? mhigh[1] : 0);
  endtask

  task automatic cyc(bit r, bit s, bit [5:0] h, bit g);
    reset = r; start_btn = s; hole_hit = h; gutter_hit = g;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    // Reset and first game
    cyc(1, 0, 6'b0, 0);
    cyc(1, 0, 6'b0, 0);
    chk("tp_rst_state", state0, 0);
    chk("tp_rst_balls", balls0, 0);
    cyc(0, 1, 6'b0, 0);
    chk("tp_start_state", state0, 1);
    chk("tp_start_balls", balls0, 3);
    cyc(0, 0, 6'b0, 0);
    cyc(0, 0, 6'b100100, 0);
    chk("tp_h52_score", score0, 100);
    chk("tp_h52_balls", balls0, 2);
    chk("tp_h52_hit", hit0, 1);
    cyc(0, 0, 6'b0, 0);
    chk("tp_hit_single", hit0, 0);
    cyc(0, 0, 6'b0, 1);
    chk("tp_gutter_balls", balls0, 1);
    chk("tp_gutter_score", score0, 100);
    cyc(0, 0, 6'b0, 0);
    cyc(0, 0, 6'b010000, 1);
    chk("tp_end_score", score0, 150);
    chk("tp_end_state", state0, 2);
    chk("tp_end_last", last0, 150);
    chk("tp_end_go", go0, 1);
    chk("tp_sat7_score", score1, 127);
    cyc(0, 0, 6'b0, 0);
    chk("tp_go_once", go0, 0);
    repeat (2) cyc(0, 0, 6'b0, 0);
    chk("tp_finish_hold", state0, 2);
    cyc(0, 0, 6'b0, 0);
    chk("tp_to_score", state0, 3);
    repeat (5) cyc(0, 0, 6'b0, 0);
    chk("tp_score_hold", state0, 3);
    cyc(0, 0, 6'b0, 0);
    chk("tp_to_menu", state0, 0);
    chk("tp_menu_score", score0, 150);

    // Second game: three 10-point holes
    cyc(0, 1, 6'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 6'b000001, 0);
      cyc(0, 0, 6'b0, 0);
    end
    chk("tp_g2_last", last0, 30);
    chk("tp_g2_high", high0, HS_EN ? 150 : 0);
    repeat (3) cyc(0, 0, 6'b0, 0);
    chk("tp_g2_score_state", state0, 3);
    cyc(0, 0, 6'b0, 0);
    cyc(0, 1, 6'b0, 0);
    chk("tp_restart_state", state0, 1);
    chk("tp_restart_score", score0, 0);
    chk("tp_restart_balls", balls0, 3);

    // Saturation on the 7-bit instance, then reset mid-game
    cyc(0, 0, 6'b0, 0);
    cyc(0, 0, 6'b100000, 0);
    cyc(0, 0, 6'b0, 0);
    cyc(0, 0, 6'b100000, 0);
    chk("tp_sat_w10", score0, 200);
    chk("tp_sat_w7", score1, 127);
    cyc(1, 0, 6'b0, 0);
    chk("tp_midrst_state", state0, 0);
    chk("tp_midrst_score", score0, 0);
    chk("tp_midrst_last", last0, 0);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 399) == 0,
          $urandom_range(0, 7) == 0,
          ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0,
          $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
